// File: rtl/cpc_bus_snoop.sv
// CPC expansion-bus snoop: qualifies Gate-Array/PAL I/O writes into RAM/ROM config pulses
// and flags memory read/write cycles. Optional stats counters under CPC_SNOOP_STATS_EN.
module cpc_bus_snoop #(
  parameter int unsigned FILTER_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iorq_b,
  input  logic        mreq_b,
  input  logic        rd_b,
  input  logic        wr_b,
  input  logic        m1_b,
  input  logic        rfsh_b,
  input  logic        adr15,
  input  logic        adr8,
  input  logic [7:0]  data,
  output logic        ram_cfg_vld,
  output logic [6:0]  ram_cfg,
  output logic        rom_cfg_vld,
  output logic [1:0]  rom_cfg,
  output logic        mwr_cyc,
  output logic        mrd_cyc,
`ifdef CPC_SNOOP_STATS_EN
  output logic [15:0] ram_cfg_cnt,
  output logic [15:0] rom_cfg_cnt,
`endif
  output logic        io_timeout
);

  localparam logic [1:0] FiltCnt = 2'(FILTER_CYCLES);
  localparam logic [7:0] ToCnt   = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StQual, StDecode, StWaitEnd} state_e;

  state_e      state_q, state_d;
  logic [1:0]  qual_cnt_q, qual_cnt_d, qual_inc;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        armed_q, armed_d, arm_clr;
  logic        ram_hit_q, ram_hit_d, rom_hit_q, rom_hit_d;
  logic [6:0]  ram_cfg_q, ram_cfg_d;
  logic [1:0]  rom_cfg_q, rom_cfg_d;
  logic        ram_vld_q, rom_vld_q;
  logic        mwr_q, mwr_d, mrd_q, mrd_d;
  logic        io_to_q, io_to_d;
  logic        io_wr, bus_fault;

  // Interrupt acknowledge (M1* low with IORQ*) never counts as an I/O write.
  assign io_wr     = !iorq_b && !wr_b && m1_b;
  assign bus_fault = !iorq_b && !mreq_b;
  assign qual_inc  = qual_cnt_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    qual_cnt_d = qual_cnt_q;
    to_cnt_d   = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
    arm_clr    = 1'b0;
    ram_hit_d  = 1'b0;
    rom_hit_d  = 1'b0;
    ram_cfg_d  = ram_cfg_q;
    rom_cfg_d  = rom_cfg_q;
    io_to_d    = io_to_q;
    unique case (state_q)
      StIdle: begin
        to_cnt_d = 8'd0;
        if (armed_q && io_wr && !bus_fault) begin
          qual_cnt_d = 2'd1;
          state_d    = (FILTER_CYCLES == 1) ? StDecode : StQual;
        end
      end
      StQual: begin
        if (io_wr) begin
          qual_cnt_d = qual_inc;
          if (qual_inc == FiltCnt) state_d = StDecode;
        end else begin
          state_d = StIdle;
        end
      end
      StDecode: begin
        state_d = StWaitEnd;
        if (!adr15 && data[7] && !bus_fault) begin
          if (data[6]) begin
            ram_hit_d = 1'b1;
            ram_cfg_d = {adr8, data[5:0]};
          end else begin
            rom_hit_d = 1'b1;
            rom_cfg_d = data[3:2];
          end
        end
      end
      StWaitEnd: begin
        if (iorq_b) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Fault and timeout both abandon the cycle; re-arm waits for IORQ* high.
    if (state_q != StIdle) begin
      if (bus_fault) begin
        state_d = StIdle;
        arm_clr = 1'b1;
      end else if (to_cnt_d == ToCnt) begin
        state_d = StIdle;
        io_to_d = 1'b1;
        arm_clr = 1'b1;
      end
    end
    armed_d = iorq_b || (armed_q && !arm_clr);
  end

  always_comb begin
    mwr_d = mwr_q;
    mrd_d = mrd_q;
    if (!mreq_b && rfsh_b && rd_b)       mwr_d = 1'b1;
    else if (mreq_b)                     mwr_d = 1'b0;
    if (!mreq_b && rfsh_b && !rd_b)      mrd_d = 1'b1;
    else if (mreq_b)                     mrd_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      qual_cnt_q <= 2'd0;
      to_cnt_q   <= 8'd0;
      armed_q    <= 1'b0;
      ram_hit_q  <= 1'b0;
      rom_hit_q  <= 1'b0;
      ram_cfg_q  <= 7'd0;
      rom_cfg_q  <= 2'd0;
      ram_vld_q  <= 1'b0;
      rom_vld_q  <= 1'b0;
      mwr_q      <= 1'b0;
      mrd_q      <= 1'b0;
      io_to_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      qual_cnt_q <= qual_cnt_d;
      to_cnt_q   <= to_cnt_d;
      armed_q    <= armed_d;
      ram_hit_q  <= ram_hit_d;
      rom_hit_q  <= rom_hit_d;
      ram_cfg_q  <= ram_cfg_d;
      rom_cfg_q  <= rom_cfg_d;
      ram_vld_q  <= ram_hit_q;
      rom_vld_q  <= rom_hit_q;
      mwr_q      <= mwr_d;
      mrd_q      <= mrd_d;
      io_to_q    <= io_to_d;
    end
  end

`ifdef CPC_SNOOP_STATS_EN
  logic [15:0] ram_cnt_q, rom_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_cnt_q <= 16'd0;
      rom_cnt_q <= 16'd0;
    end else begin
      if (ram_hit_q && ram_cnt_q != 16'hFFFF) ram_cnt_q <= ram_cnt_q + 16'd1;
      if (rom_hit_q && rom_cnt_q != 16'hFFFF) rom_cnt_q <= rom_cnt_q + 16'd1;
    end
  end

  assign ram_cfg_cnt = ram_cnt_q;
  assign rom_cfg_cnt = rom_cnt_q;
`endif

  assign ram_cfg_vld = ram_vld_q;
  assign ram_cfg     = ram_cfg_q;
  assign rom_cfg_vld = rom_vld_q;
  assign rom_cfg     = rom_cfg_q;
  assign mwr_cyc     = mwr_q;
  assign mrd_cyc     = mrd_q;
  assign io_timeout  = io_to_q;

endmodule

// File: tb/tb_cpc_bus_snoop.sv
// Directed bench for cpc_bus_snoop: one instance with FILTER_CYCLES=1, one with 2.
module tb_cpc_bus_snoop;

  logic clk = 1'b0;
  logic reset;
  logic iorq_b, mreq_b, rd_b, wr_b, m1_b, rfsh_b, adr15, adr8;
  logic [7:0] data;

  logic       r1_vld, o1_vld, mwr1, mrd1, to1;
  logic [6:0] r1_cfg;
  logic [1:0] o1_cfg;
  logic       r2_vld, o2_vld, mwr2, mrd2, to2;
  logic [6:0] r2_cfg;
  logic [1:0] o2_cfg;
`ifdef CPC_SNOOP_STATS_EN
  logic [15:0] r1_cnt, o1_cnt, r2_cnt, o2_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpc_bus_snoop #(.FILTER_CYCLES(1), .TIMEOUT_CYCLES(15)) dut1 (
    .clk(clk), .reset(reset), .iorq_b(iorq_b), .mreq_b(mreq_b), .rd_b(rd_b), .wr_b(wr_b),
    .m1_b(m1_b), .rfsh_b(rfsh_b), .adr15(adr15), .adr8(adr8), .data(data),
    .ram_cfg_vld(r1_vld), .ram_cfg(r1_cfg), .rom_cfg_vld(o1_vld), .rom_cfg(o1_cfg),
    .mwr_cyc(mwr1), .mrd_cyc(mrd1),
`ifdef CPC_SNOOP_STATS_EN
    .ram_cfg_cnt(r1_cnt), .rom_cfg_cnt(o1_cnt),
`endif
    .io_timeout(to1)
  );

  cpc_bus_snoop #(.FILTER_CYCLES(2), .TIMEOUT_CYCLES(15)) dut2 (
    .clk(clk), .reset(reset), .iorq_b(iorq_b), .mreq_b(mreq_b), .rd_b(rd_b), .wr_b(wr_b),
    .m1_b(m1_b), .rfsh_b(rfsh_b), .adr15(adr15), .adr8(adr8), .data(data),
    .ram_cfg_vld(r2_vld), .ram_cfg(r2_cfg), .rom_cfg_vld(o2_vld), .rom_cfg(o2_cfg),
    .mwr_cyc(mwr2), .mrd_cyc(mrd2),
`ifdef CPC_SNOOP_STATS_EN
    .ram_cfg_cnt(r2_cnt), .rom_cfg_cnt(o2_cnt),
`endif
    .io_timeout(to2)
  );

  // Inputs change 1 ns after a rising edge and are sampled at the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    iorq_b = 1'b1; mreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
    m1_b = 1'b1; rfsh_b = 1'b1; adr15 = 1'b0; adr8 = 1'b0; data = 8'h00;
  endtask

  task automatic io_write(input logic [7:0] d, input logic a8, input logic a15);
    iorq_b = 1'b0; wr_b = 1'b0; m1_b = 1'b1; data = d; adr8 = a8; adr15 = a15;
  endtask

  task automatic idle_ticks(input int n);
    bus_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    bus_idle();
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    n_vec++; if (r1_vld !== 1'b0) begin n_err++; $display("FAIL reset_ram_vld got %b want 0", r1_vld); end
    n_vec++; if (r1_cfg !== 7'd0) begin n_err++; $display("FAIL reset_ram_cfg got %h want 00", r1_cfg); end
    n_vec++; if (o1_vld !== 1'b0) begin n_err++; $display("FAIL reset_rom_vld got %b want 0", o1_vld); end
    n_vec++; if (o1_cfg !== 2'd0) begin n_err++; $display("FAIL reset_rom_cfg got %b want 00", o1_cfg); end
    n_vec++; if (mwr1 !== 1'b0) begin n_err++; $display("FAIL reset_mwr got %b want 0", mwr1); end
    n_vec++; if (mrd1 !== 1'b0) begin n_err++; $display("FAIL reset_mrd got %b want 0", mrd1); end
    n_vec++; if (to1 !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", to1); end
    idle_ticks(2);
  endtask

  task automatic test_ram_cfg();
    io_write(8'hC6, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 3) bus_idle();
      n_vec++;
      if (r1_vld !== (i == 2)) begin
        n_err++; $display("FAIL ram_vld_f1 clk%0d got %b want %b", i, r1_vld, (i == 2));
      end
      n_vec++;
      if (o1_vld !== 1'b0) begin n_err++; $display("FAIL ram_no_rom clk%0d got %b want 0", i, o1_vld); end
      if (i == 2) begin
        n_vec++;
        if (r1_cfg !== 7'b1000110) begin
          n_err++; $display("FAIL ram_cfg_f1 got %b want 1000110", r1_cfg);
        end
      end
    end
    idle_ticks(2);
  endtask

  task automatic test_rom_cfg();
    io_write(8'h8C, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) bus_idle();
      n_vec++;
      if (o1_vld !== (i == 2)) begin
        n_err++; $display("FAIL rom_vld_f1 clk%0d got %b want %b", i, o1_vld, (i == 2));
      end
      n_vec++;
      if (r1_vld !== 1'b0) begin n_err++; $display("FAIL rom_no_ram clk%0d got %b want 0", i, r1_vld); end
      if (i == 2) begin
        n_vec++;
        if (o1_cfg !== 2'b11) begin n_err++; $display("FAIL rom_cfg_f1 got %b want 11", o1_cfg); end
      end
    end
    idle_ticks(2);
  endtask

  task automatic test_filter();
    // Single-clock glitch must not pass a two-sample filter.
    io_write(8'hC6, 1'b1, 1'b0);
    tick();
    bus_idle();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (r2_vld !== 1'b0) begin n_err++; $display("FAIL glitch_f2 clk%0d got %b want 0", i, r2_vld); end
      tick();
    end
    io_write(8'hC5, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) bus_idle();
      n_vec++;
      if (r2_vld !== (i == 3)) begin
        n_err++; $display("FAIL ram_vld_f2 clk%0d got %b want %b", i, r2_vld, (i == 3));
      end
      if (i == 3) begin
        n_vec++;
        if (r2_cfg !== 7'b0000101) begin n_err++; $display("FAIL ram_cfg_f2 got %b want 0000101", r2_cfg); end
      end
    end
    idle_ticks(2);
  endtask

  task automatic test_ignored();
    int pulses;
    pulses = 0;
    io_write(8'hC1, 1'b0, 1'b0);
    m1_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 3) bus_idle();
      if (r1_vld || o1_vld || r2_vld || o2_vld) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin n_err++; $display("FAIL int_ack_ignored got %0d pulses want 0", pulses); end
    idle_ticks(2);
    pulses = 0;
    io_write(8'hC1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 3) bus_idle();
      if (r1_vld || o1_vld || r2_vld || o2_vld) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin n_err++; $display("FAIL adr15_ignored got %0d pulses want 0", pulses); end
    idle_ticks(2);
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    io_write(8'hC6, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (r1_vld) pulses++;
      if (i == 14) begin
        n_vec++;
        if (to1 !== 1'b0) begin n_err++; $display("FAIL timeout_early got %b want 0", to1); end
      end
      if (i == 15) begin
        n_vec++;
        if (to1 !== 1'b1) begin n_err++; $display("FAIL timeout_set got %b want 1", to1); end
      end
    end
    n_vec++;
    if (pulses !== 1) begin n_err++; $display("FAIL timeout_one_pulse got %0d want 1", pulses); end
    n_vec++;
    if (to2 !== 1'b1) begin n_err++; $display("FAIL timeout_f2 got %b want 1", to2); end
    idle_ticks(2);
    n_vec++;
    if (to1 !== 1'b1) begin n_err++; $display("FAIL timeout_sticky got %b want 1", to1); end

    // Reset in the middle of a held write: no pulse until IORQ* releases.
    io_write(8'hC6, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_vec++;
    if (to1 !== 1'b0) begin n_err++; $display("FAIL reset_clears_timeout got %b want 0", to1); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (r1_vld) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin n_err++; $display("FAIL no_pulse_after_reset got %0d want 0", pulses); end
    iorq_b = 1'b1;
    tick();
    io_write(8'hC6, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (r1_vld) pulses++;
    end
    bus_idle();
    tick();
    n_vec++;
    if (pulses !== 1) begin n_err++; $display("FAIL rearm_pulse got %0d want 1", pulses); end
    idle_ticks(2);
  endtask

  task automatic test_mem_cycles();
    mreq_b = 1'b0; rd_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) mreq_b = 1'b1;
      n_vec++;
      if (mwr1 !== (i < 3)) begin n_err++; $display("FAIL mwr clk%0d got %b want %b", i, mwr1, (i < 3)); end
      n_vec++;
      if (mrd1 !== 1'b0) begin n_err++; $display("FAIL mwr_no_mrd clk%0d got %b want 0", i, mrd1); end
    end
    mreq_b = 1'b0; rd_b = 1'b0;
    tick();
    n_vec++;
    if (mrd1 !== 1'b1) begin n_err++; $display("FAIL mrd_set got %b want 1", mrd1); end
    bus_idle();
    tick();
    n_vec++;
    if (mrd1 !== 1'b0) begin n_err++; $display("FAIL mrd_clr got %b want 0", mrd1); end
    mreq_b = 1'b0; rfsh_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if ({mwr1, mrd1} !== 2'b00) begin
        n_err++; $display("FAIL refresh clk%0d got %b want 00", i, {mwr1, mrd1});
      end
    end
    idle_ticks(2);
  endtask

  task automatic test_bus_fault();
    int pulses;
    pulses = 0;
    io_write(8'hC6, 1'b1, 1'b0);
    tick();
    mreq_b = 1'b0;
    tick();
    n_vec++;
    if (mwr1 !== 1'b1) begin n_err++; $display("FAIL fault_mwr got %b want 1", mwr1); end
    if (r1_vld || r2_vld) pulses++;
    mreq_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (r1_vld || r2_vld) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin n_err++; $display("FAIL fault_no_pulse got %0d want 0", pulses); end
    idle_ticks(2);
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      io_write(8'hC0 | 8'(k), 1'b0, 1'b0);
      tick(); tick();
      iorq_b = 1'b1;
      tick();
      if (r1_vld) pulses++;
      tick();
      if (r1_vld) pulses++;
    end
    n_vec++;
    if (pulses !== 3) begin n_err++; $display("FAIL back_to_back got %0d pulses want 3", pulses); end
    n_vec++;
    if (r1_cfg !== 7'b0000010) begin n_err++; $display("FAIL back_to_back_cfg got %b want 0000010", r1_cfg); end
`ifdef CPC_SNOOP_STATS_EN
    n_vec++;
    if (r1_cnt !== 16'd3) begin n_err++; $display("FAIL stats_ram got %0d want 3", r1_cnt); end
    n_vec++;
    if (o1_cnt !== 16'd0) begin n_err++; $display("FAIL stats_rom got %0d want 0", o1_cnt); end
`endif
    idle_ticks(2);
  endtask

  initial begin
    bus_idle();
    reset = 1'b1;
    test_reset();
    test_ram_cfg();
    test_rom_cfg();
    test_filter();
    test_ignored();
    test_timeout();
    test_mem_cycles();
    test_bus_fault();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    idle_ticks(2);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpc_bus_snoop.md
Name: cpc_bus_snoop

Overview:
- Upstream front-end for the RAM-expansion mapper.
- Samples the CPC expansion-bus strobes on `clk` and classifies each Z80 cycle.
- Detects Gate-Array/PAL I/O writes:
  - RAM config (A15=0, D7:6=11).
  - ROM config (A15=0, D7:6=10).
- Emits registered, single-pulse config updates plus clean memory-write/read cycle flags for the mapper and CPLD-side decode.

Parameters:
- FILTER_CYCLES, 1: consecutive samples with IORQ*=0 & WR*=0 needed to qualify an I/O write (1..3).
- TIMEOUT_CYCLES, 15: max clocks an I/O cycle may stay active before abort (4..255).

Ports:
- clk  in  1  bus clock (CPC 4 MHz CLK)
- reset  in  1  synchronous, active-high reset
- iorq_b  in  1  Z80 IORQ*, active low
- mreq_b  in  1  Z80 MREQ*, active low
- rd_b  in  1  Z80 RD*, active low
- wr_b  in  1  Z80 WR*, active low
- m1_b  in  1  Z80 M1*, active low (IORQ*&M1* = interrupt ack, ignored)
- rfsh_b  in  1  Z80 RFSH*, active low
- adr15  in  1  address bit 15
- adr8  in  1  address bit 8 (selects 7FFF vs 7FFE RAM bank half)
- data  in  8  data bus
- ram_cfg_vld  out  1  one-clock pulse: new RAM config
- ram_cfg  out  7  {adr8, data[5:0]} captured at qualification
- rom_cfg_vld  out  1  one-clock pulse: new ROM config
- rom_cfg  out  2  data[3:2] {urom_disable, lrom_disable}
- mwr_cyc  out  1  memory write cycle in progress
- mrd_cyc  out  1  memory read (non-refresh) cycle in progress
- io_timeout  out  1  sticky: an I/O cycle exceeded TIMEOUT_CYCLES

Behaviour:
- All outputs registered. All outputs reset to 0; FSM reset to IDLE; counters reset to 0.
- FSM states: IDLE, QUAL, DECODE, WAIT_END.
- IDLE:
  - If iorq_b=0 & wr_b=0 & m1_b=1: load qual_cnt=1.
  - If FILTER_CYCLES==1, go to DECODE; otherwise go to QUAL.
- QUAL:
  - While the condition holds, qual_cnt++.
  - When qual_cnt reaches FILTER_CYCLES, go to DECODE.
  - If the condition drops first, return to IDLE with no pulse.
- DECODE (one clock):
  - Capture data/adr8/adr15 sampled this clock.
  - adr15=0, data[7:6]=11: ram_cfg <= {adr8, data[5:0]}; ram_cfg_vld=1 next clock.
  - adr15=0, data[7:6]=10: rom_cfg <= data[3:2]; rom_cfg_vld=1 next clock.
  - Any other decode: no pulse.
  - Always go to WAIT_END.
  - Latency from first qualifying sample to pulse: FILTER_CYCLES+1 clocks.
- WAIT_END:
  - Stay until iorq_b=1 sampled, then go to IDLE.
  - Exactly one pulse per I/O cycle, however long IORQ* is held.
- Timeout:
  - to_cnt counts clocks in QUAL/DECODE/WAIT_END and saturates.
  - When to_cnt==TIMEOUT_CYCLES: set io_timeout and force IDLE.
  - The FSM does not re-arm until iorq_b=1 has been seen (re-arm flag).
  - io_timeout clears only on reset.
- Interrupt ack (iorq_b=0 & m1_b=0) is never qualified.
- mwr_cyc:
  - Set when mreq_b=0 & rd_b=1 & rfsh_b=1 sampled.
  - Cleared when mreq_b=1 sampled.
  - Set has priority over clear.
- mrd_cyc:
  - Set when mreq_b=0 & rd_b=0 & rfsh_b=1.
  - Cleared when mreq_b=1.
- Refresh cycles (rfsh_b=0) never set either flag.
- Simultaneous MREQ* and IORQ* low is treated as a bus fault: the I/O path returns to IDLE with no pulse, and the memory flags are unaffected.
- Reset mid-cycle: FSM goes to IDLE immediately; no pulse is generated for the interrupted cycle, even if IORQ* is still low after reset releases. Re-arm requires iorq_b=1 first.

Optional Feature:
- Macro: CPC_SNOOP_STATS_EN.
- Defined:
  - Adds outputs ram_cfg_cnt[15:0] and rom_cfg_cnt[15:0].
  - Each counter increments on its vld pulse, saturates at 16'hFFFF and resets to 0.
- Undefined:
  - Ports and counters are absent.
  - All other behaviour is identical.

Test Plan:
- FILTER_CYCLES=1; iorq_b=0, wr_b=0, adr15=0, adr8=1, data=8'hC6 for 4 clocks -> ram_cfg_vld one clock, 2 clocks after first sample; ram_cfg=7'b1000110; no further pulse.
- data=8'h8C, adr15=0 I/O write -> rom_cfg_vld single pulse; rom_cfg=2'b11; ram_cfg_vld stays 0.
- FILTER_CYCLES=2; 1-clock IORQ*/WR* glitch -> no pulse. 3-clock assertion -> pulse, 3 clocks after first sample.
- iorq_b=0, m1_b=0, data=8'hC1 -> no pulse. I/O write with adr15=1, data=8'hC1 -> no pulse.
- TIMEOUT_CYCLES=15; hold I/O write 40 clocks -> io_timeout=1 from clock 15, exactly one ram_cfg_vld. Reset mid-hold -> io_timeout=0, no pulse until IORQ* released and re-asserted.
- Memory write mreq_b=0, rd_b=1 for 3 clocks -> mwr_cyc=1 one clock later, cleared one clock after mreq_b=1. Refresh cycle with rfsh_b=0 -> mwr_cyc=0, mrd_cyc=0. With CPC_SNOOP_STATS_EN, 3 RAM writes -> ram_cfg_cnt=3.
